// File: rtl/sqwave_pkg.sv
// Shared types and width helpers for the multi-channel square-wave generator.
// Pure declarations: no logic, no latency, no backpressure.
package sqwave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    function automatic int cnt_w(input int m, input int n);
        return (m > n) ? m : n;
    endfunction

    // A single-channel build still gets a 1-bit select port.
    function automatic int sel_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/sqwave_channel.sv
// One square-wave channel: IDLE/HIGH/LOW FSM, active m/n registers and a tick counter.
// Latency: out/period_start update on the edge of the causing tick; en=0 acts on the next clk; no backpressure.
module sqwave_channel
    import sqwave_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         en,
    input  logic [M-1:0] sh_m,
    input  logic [N-1:0] sh_n,
    output logic         out,
    output logic         period_start
);

    localparam int CW = cnt_w(M, N);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [M-1:0]   act_m, act_m_nx;
    logic [N-1:0]   act_n, act_n_nx;
    logic           out_nx, ps_nx;

    // One extra bit so cnt+1 never wraps before the compare.
    logic [CW:0]    cnt_inc;
    logic [CW:0]    m_ext;
    logic [CW:0]    n_ext;
    logic           boundary;

    assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
    assign m_ext   = (CW+1)'(act_m);
    assign n_ext   = (CW+1)'(act_n);

    assign boundary = tick && ((state == IDLE) ||
                               (state == LOW  && cnt_inc >= n_ext) ||
                               (state == HIGH && cnt_inc >= m_ext && act_n == '0));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        act_m_nx = act_m;
        act_n_nx = act_n;
        out_nx   = out;
        ps_nx    = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            out_nx   = 1'b0;
            cnt_nx   = '0;
        end else if (boundary) begin
            act_m_nx = sh_m;
            act_n_nx = sh_n;
            cnt_nx   = '0;
            ps_nx    = 1'b1;
            if (sh_m != '0) begin
                state_nx = HIGH;
                out_nx   = 1'b1;
            end else begin
                state_nx = LOW;
                out_nx   = 1'b0;
            end
        end else if (tick) begin
            case (state)
                HIGH: begin
                    if (cnt_inc >= m_ext) begin
                        state_nx = LOW;
                        out_nx   = 1'b0;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc[CW-1:0];
                    end
                end
                LOW:     cnt_nx = cnt_inc[CW-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            act_m        <= '0;
            act_n        <= '0;
            out          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            act_m        <= act_m_nx;
            act_n        <= act_n_nx;
            out          <= out_nx;
            period_start <= ps_nx;
        end
    end

endmodule

// File: rtl/multi_sqwave_gen.sv
// CH-channel m/n square-wave generator: shared tick prescaler, shadow m/n per channel, one FSM per channel.
// Latency: outputs registered, change on the tick edge; shadow writes apply at the next period boundary; no backpressure.
module multi_sqwave_gen
    import sqwave_pkg::*;
#(
    parameter int CH       = 4,
    parameter int M        = 4,
    parameter int N        = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH-1:0]          en,
    input  logic                   load,
    input  logic [sel_w(CH)-1:0]   ch_sel,
    input  logic [M-1:0]           m_in,
    input  logic [N-1:0]           n_in,
    output logic [CH-1:0]          out,
    output logic [CH-1:0]          period_start
);

    localparam int SEL_W = sel_w(CH);
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;
    logic          tick;
    logic [M-1:0]  sh_m [CH];
    logic [N-1:0]  sh_n [CH];

    assign tick = (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Out-of-range selects match no channel, so the write is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                sh_m[i] <= '0;
                sh_n[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < CH; i++) begin
                if (ch_sel == SEL_W'(i)) begin
                    sh_m[i] <= m_in;
                    sh_n[i] <= n_in;
                end
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        sqwave_channel #(
            .M (M),
            .N (N)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .en           (en[g]),
            .sh_m         (sh_m[g]),
            .sh_n         (sh_n[g]),
            .out          (out[g]),
            .period_start (period_start[g])
        );
    end

endmodule

// File: tb/tb_multi_sqwave_gen.sv
// Bench for multi_sqwave_gen: period-position reference model checked every cycle, plus directed literal checks.
module tb_multi_sqwave_gen;

    localparam int CH = 4;
    localparam int TD = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] en = '0;
    logic          load = 1'b0;
    logic [1:0]    ch_sel = '0;
    logic [3:0]    m_in = '0;
    logic [3:0]    n_in = '0;
    logic [CH-1:0] out;
    logic [CH-1:0] period_start;

    always #5 clk = ~clk;

    multi_sqwave_gen #(
        .CH       (CH),
        .M        (4),
        .N        (4),
        .TICK_DIV (TD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .load         (load),
        .ch_sel       (ch_sel),
        .m_in         (m_in),
        .n_in         (n_in),
        .out          (out),
        .period_start (period_start)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel tracks its tick position inside the current period.
    int            cyc;
    bit            run [CH];
    int            pos [CH];
    int            am  [CH];
    int            an  [CH];
    int            shm [CH];
    int            shn [CH];
    logic [CH-1:0] exp_out = '0;
    logic [CH-1:0] exp_ps  = '0;

    function automatic int plen(input int m, input int n);
        if (m > 0) return (n > 0) ? m + n : m;
        return (n > 0) ? n : 1;
    endfunction

    always @(posedge clk) begin
        bit tk;
        bit bnd;
        if (!rst) begin
            cyc     = 0;
            exp_out = '0;
            exp_ps  = '0;
            for (int c = 0; c < CH; c++) begin
                run[c] = 0; pos[c] = 0; am[c] = 0; an[c] = 0; shm[c] = 0; shn[c] = 0;
            end
        end else begin
            tk = ((cyc % TD) == TD - 1);
            cyc++;
            for (int c = 0; c < CH; c++) begin
                exp_ps[c] = 1'b0;
                if (!en[c]) begin
                    run[c]     = 0;
                    exp_out[c] = 1'b0;
                end else if (tk) begin
                    if (!run[c]) begin
                        bnd = 1;
                    end else begin
                        pos[c]++;
                        bnd = (pos[c] >= plen(am[c], an[c]));
                    end
                    if (bnd) begin
                        run[c]     = 1;
                        am[c]      = shm[c];
                        an[c]      = shn[c];
                        pos[c]     = 0;
                        exp_ps[c]  = 1'b1;
                        exp_out[c] = (am[c] > 0);
                    end else begin
                        exp_out[c] = (pos[c] < am[c]);
                    end
                end
            end
            if (load && ch_sel < CH) begin
                shm[ch_sel] = m_in;
                shn[ch_sel] = n_in;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("out_vs_model", out, exp_out);
            chk("period_start_vs_model", period_start, exp_ps);
        end
    end

    task automatic do_load(input int c, input int m, input int n);
        @(negedge clk);
        load   = 1'b1;
        ch_sel = 2'(c);
        m_in   = 4'(m);
        n_in   = 4'(n);
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_ps(input int c, output int waited);
        bit ok;
        ok     = 0;
        waited = 0;
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            if (period_start[c]) begin
                ok     = 1;
                waited = i;
                break;
            end
        end
        chk("wait_period_start_timeout", int'(ok), 1);
    endtask

    int hi [CH];
    int pc [CH];
    int w, w2;
    bit found;

    initial begin
        rst = 1'b0;
        en  = '1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_out", out, 0);
            chk("reset_period_start", period_start, 0);
        end
        en  = '0;
        rst = 1'b1;

        do_load(0, 1, 0);
        do_load(1, 0, 1);
        do_load(2, 2, 1);
        do_load(3, 1, 2);
        en = 4'hF;
        repeat (20) @(negedge clk);

        wait_ps(2, w);
        chk("ch3_boundary_with_ch2", period_start[3], 1);
        chk("ch3_high_at_start", out[3], 1);

        for (int c = 0; c < CH; c++) begin hi[c] = 0; pc[c] = 0; end
        repeat (300) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                hi[c] += out[c];
                pc[c] += period_start[c];
            end
        end
        chk("ch0_high_cycles", hi[0], 300);
        chk("ch1_high_cycles", hi[1], 0);
        chk("ch2_high_cycles", hi[2], 200);
        chk("ch3_high_cycles", hi[3], 100);
        chk("ch0_pulses", pc[0], 30);
        chk("ch1_pulses", pc[1], 30);
        chk("ch2_pulses", pc[2], 10);
        chk("ch3_pulses", pc[3], 10);

        // Reload ch2 during HIGH: old 2/1 period must finish first.
        wait_ps(2, w);
        do_load(2, 1, 1);
        wait_ps(2, w);
        chk("reload_old_period_cycles", w + 2, 30);
        hi[2] = 0; pc[2] = 0;
        repeat (200) begin
            @(negedge clk);
            hi[2] += out[2];
            pc[2] += period_start[2];
        end
        chk("reload_new_high_cycles", hi[2], 100);
        chk("reload_new_pulses", pc[2], 10);

        // Load ch3 on the very edge of its boundary.
        wait_ps(3, w);
        repeat (29) @(negedge clk);
        load = 1'b1; ch_sel = 2'd3; m_in = 4'd3; n_in = 4'd3;
        @(negedge clk);
        load = 1'b0;
        chk("coincident_boundary", period_start[3], 1);
        wait_ps(3, w);
        chk("coincident_old_period", w, 30);
        wait_ps(3, w2);
        chk("coincident_new_period", w2, 60);

        // Disable ch2 mid-HIGH, then re-enable.
        wait_ps(2, w);
        @(negedge clk);
        chk("ch2_high_before_disable", out[2], 1);
        en[2] = 1'b0;
        @(negedge clk);
        chk("ch2_low_after_disable", out[2], 0);
        repeat (15) @(negedge clk);
        en[2] = 1'b1;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out[2]) begin found = 1; break; end
        end
        chk("reenable_rise_within_tick", int'(found), 1);
        chk("reenable_rise_with_pulse", period_start[2], 1);

        // Randomized enables and loads.
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, CH - 1)] ^= 1'b1;
            load = ($urandom_range(0, 24) == 0);
            if (load) begin
                ch_sel = 2'($urandom_range(0, 3));
                m_in   = 4'($urandom_range(0, 5));
                n_in   = 4'($urandom_range(0, 5));
            end
        end
        @(negedge clk);
        load = 1'b0;

        // Asynchronous reset while ch0 is high.
        do_load(0, 1, 0);
        en[0] = 1'b0;
        @(negedge clk);
        en[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out[0]) begin found = 1; break; end
        end
        chk("ch0_high_before_async_reset", int'(found), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_reset_out", out, 0);
        chk("async_reset_period_start", period_start, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_sqwave_gen.md
Name: multi_sqwave_gen

Overview:
- Multi-channel programmable square-wave generator; next generation of the single-channel m/n generator.
- Each of CH channels drives HIGH for m ticks and LOW for n ticks, where one tick = TICK_DIV clocks (default 100 ns at 100 MHz).
- Adds a per-channel enable, double-buffered (shadow) settings applied only at period boundaries, and a period-start strobe.
- Sits between a control/register interface and I/O pins or LEDs.

Parameters:
- CH, 4, number of independent channels (1..16)
- M, 4, width of the high-time field m, in ticks
- N, 4, width of the low-time field n, in ticks
- TICK_DIV, 10, clocks per tick (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- en  in  CH  per-channel enable, level-sensitive
- load  in  1  one-clock strobe: write m_in/n_in into the shadow of channel ch_sel
- ch_sel  in  $clog2(CH) (min 1)  target channel for load
- m_in  in  M  high-time in ticks
- n_in  in  N  low-time in ticks
- out  out  CH  square-wave outputs, registered
- period_start  out  CH  one-clock pulse per channel at each period boundary

Behaviour:
- Reset (rst=0, asynchronous):
  - out=0, period_start=0.
  - Prescaler=0; all shadow and active m/n=0; counters=0; all channels IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle when count==TICK_DIV-1. First tick is at clock TICK_DIV-1 after reset release.
  - TICK_DIV=1 gives tick every cycle.
  - Free-running; shared by all channels; unaffected by en.
- Shadow write:
  - On load=1, sh_m[ch_sel]<=m_in and sh_n[ch_sel]<=n_in.
  - ch_sel>=CH: write ignored.
  - Writes never alter the active values directly.
- Per-channel FSM states: IDLE, HIGH, LOW. Registers: act_m, act_n, cnt (width max(M,N)).
- Boundary event, evaluated only on tick:
  - (IDLE and en=1), or
  - (LOW and cnt+1>=act_n), or
  - (HIGH and cnt+1>=act_m and act_n==0).
- At a boundary:
  - act<=shadow (registered shadow value; a load in the same cycle takes effect at the next boundary); cnt<=0; period_start pulses for 1 clk.
  - If sh_m>0: go to HIGH, out<=1. Otherwise go to LOW, out<=0.
- HIGH, on tick without boundary:
  - If cnt+1>=act_m: go to LOW, out<=0, cnt<=0.
  - Otherwise cnt<=cnt+1.
- LOW, on tick without boundary: cnt<=cnt+1.
- Resulting waveforms:
  - m>0, n>0: period (m+n) ticks, duty m/(m+n).
  - m>0, n=0: out constant 1, period_start every m ticks.
  - m=0, n>0: out constant 0, period_start every n ticks.
  - m=0, n=0: out 0, period_start every tick.
- Latency: out changes on the same clock edge as the tick that causes the transition (one register stage).
- en=0 in any state: next clk go to IDLE, out<=0, cnt<=0, no period_start. Takes effect immediately, not on a tick.
- Re-enable: the first tick with en=1 is a boundary, so the new period starts phase-aligned to the tick.
- Channels are fully independent apart from the shared tick.
- Counters never wrap: cnt is bounded by act_m-1 or act_n-1.

Decomposition:
- Package sqwave_pkg:
  - state enum (IDLE, HIGH, LOW)
  - function cnt_w(M,N) returning max(M,N)
  - localparam-derived SEL_W helper
- Top level: prescaler, shadow register array, and a generate loop.
- One sub-module, sqwave_channel: per-channel FSM, active registers, counter.
  - Inputs: tick, en, sh_m, sh_n.
  - Outputs: out, period_start.

Test Plan (CH=4, M=N=4, TICK_DIV=10, clk period 10 ns):
- Reset: hold rst=0 for 3 clks with en=4'hF → out=0 and period_start=0 throughout. Assert rst=0 mid-run with ch0 high → out[0]=0 immediately, without waiting for a clock edge.
- Load ch0 m=1 n=0, en[0]=1 → out[0] goes 1 at the first tick and stays 1. period_start[0] pulses every 100 ns.
- Load ch1 m=0 n=1, en[1]=1 → out[1] stays 0. period_start[1] pulses every 100 ns.
- Load ch2 m=2 n=1 and ch3 m=1 n=2, both enabled → ch2 shows 200 ns high / 100 ns low. ch3 shows 100 ns high / 200 ns low. Both have a 300 ns period, and both start high on the same tick.
- Mid-period reload: ch2 running m=2 n=1, load m=1 n=1 during HIGH → current period completes as 2/1. Next period is 1/1. Change occurs exactly at the period_start pulse.
- Load with ch_sel=3 coincident with ch3 boundary → old values are used for that period and new values from the next boundary. en[2]=0 mid-HIGH → out[2]=0 on the next clk. Re-enable → out[2]=1 on the next tick.
